reu_host_seq: RTL and testbench



---
 rtl/reu_host_seq.sv | 270 +++++++++++++++++++++++++++
 tb/tb_reu_host_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reu_host_seq.sv
// Host-side 6502-style bus initiator: programs the REU register page, starts a
// transfer, polls $DF00 until end-of-block and reports the outcome.
module reu_host_seq #(
    parameter logic [7:0]  IO2_PAGE = 8'hDF,
    parameter logic [19:0] TIMEOUT  = 20'hFFFFF
) (
    input  logic        C8M,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  XTYPE,
    input  logic [15:0] CADDR,
    input  logic [23:0] RADDR,
    input  logic [15:0] LEN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [7:0]  STATUS,
    output logic        PHI2,
    output logic [15:0] A_O,
    output logic        AOE,
    input  logic [7:0]  D_I,
    output logic [7:0]  D_O,
    output logic        DOE,
    output logic        nWE,
    output logic        nIO2,
    input  logic        nDMA
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_POLL = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t      state_r, stateNext_s;
    logic [2:0]  ph_r;
    logic [3:0]  idx_r, idxNext_s;
    logic [19:0] pollCnt_r, pollNext_s, pollInc_s;
    logic        pend_r, pendNext_s;
    logic        accept_s, cycEnd_s, busCycle_s;
    logic        busy_r, busyNext_s, done_r, doneNext_s, err_r, errNext_s;
    logic [7:0]  status_r, statusNext_s;
    logic        actv_r, actvNext_s;
    logic [15:0] ao_r, aoNext_s;
    logic        aoe_r, aoeNext_s, nWe_r, nWeNext_s, nIo2_r, nIo2Next_s;
    logic [7:0]  do_r, doNext_s;
    logic        doe_r, doeNext_s;
    logic [1:0]  xtype_r;
    logic [15:0] caddr_r, len_r;
    logic [23:0] raddr_r;

    // Register offset written in each step of the programming sequence.
    function automatic logic [3:0] wrReg(input logic [3:0] idx);
        case (idx)
            4'd0:    wrReg = 4'h2;
            4'd1:    wrReg = 4'h3;
            4'd2:    wrReg = 4'h4;
            4'd3:    wrReg = 4'h5;
            4'd4:    wrReg = 4'h6;
            4'd5:    wrReg = 4'h7;
            4'd6:    wrReg = 4'h8;
            4'd7:    wrReg = 4'hA;
            4'd8:    wrReg = 4'h1;
            default: wrReg = 4'h0;
        endcase
    endfunction

    // Data byte for each step; the final command byte sets execute with FF00 decode off.
    function automatic logic [7:0] wrData(input logic [3:0]  idx,
                                          input logic [15:0] ca,
                                          input logic [23:0] ra,
                                          input logic [15:0] ln,
                                          input logic [1:0]  xt);
        case (idx)
            4'd0:    wrData = ca[7:0];
            4'd1:    wrData = ca[15:8];
            4'd2:    wrData = ra[7:0];
            4'd3:    wrData = ra[15:8];
            4'd4:    wrData = ra[23:16];
            4'd5:    wrData = ln[7:0];
            4'd6:    wrData = ln[15:8];
            4'd7:    wrData = 8'h00;
            4'd8:    wrData = 8'h90 | {6'b000000, xt};
            default: wrData = 8'h00;
        endcase
    endfunction

    assign cycEnd_s = (ph_r == 3'd7);

    // Sequence control: step selection, polling, completion and result capture.
    always_comb begin
        stateNext_s  = state_r;
        idxNext_s    = idx_r;
        pollNext_s   = pollCnt_r;
        pendNext_s   = pend_r;
        busyNext_s   = busy_r;
        doneNext_s   = 1'b0;
        errNext_s    = err_r;
        statusNext_s = status_r;
        accept_s     = 1'b0;
        pollInc_s    = (pollCnt_r == TIMEOUT) ? pollCnt_r : pollCnt_r + 20'd1;
        case (state_r)
            ST_IDLE: begin
                if (cycEnd_s && (START || pend_r)) begin
                    accept_s     = 1'b1;
                    stateNext_s  = ST_WR;
                    idxNext_s    = 4'd0;
                    pendNext_s   = 1'b0;
                    busyNext_s   = 1'b1;
                    errNext_s    = 1'b0;
                    statusNext_s = 8'h00;
                end else if (START) begin
                    pendNext_s = 1'b1;
                end else begin
                    pendNext_s = pend_r;
                end
            end
            ST_WR: begin
                if (cycEnd_s && actv_r) begin
                    if (idx_r == 4'd8) begin
                        stateNext_s = ST_POLL;
                        idxNext_s   = 4'd0;
                        pollNext_s  = 20'd0;
                    end else begin
                        idxNext_s = idx_r + 4'd1;
                    end
                end else begin
                    idxNext_s = idx_r;
                end
            end
            ST_POLL: begin
                if (cycEnd_s) begin
                    pollNext_s = pollInc_s;
                    if (actv_r) begin
                        statusNext_s = D_I;
                    end else begin
                        statusNext_s = status_r;
                    end
                    if (actv_r && D_I[6]) begin
                        stateNext_s = ST_FIN;
                        doneNext_s  = 1'b1;
                        busyNext_s  = 1'b0;
                        errNext_s   = (xtype_r == 2'b11) & D_I[5];
                    end else if (pollInc_s == TIMEOUT) begin
                        stateNext_s = ST_FIN;
                        doneNext_s  = 1'b1;
                        busyNext_s  = 1'b0;
                        errNext_s   = 1'b1;
                    end else begin
                        stateNext_s = ST_POLL;
                    end
                end else begin
                    pollNext_s = pollCnt_r;
                end
            end
            ST_FIN: begin
                stateNext_s = ST_IDLE;
            end
            default: begin
                stateNext_s = ST_IDLE;
            end
        endcase
    end

    // Bus pins for the upcoming cycle are decided at the PH=7 edge, from nDMA and the next step.
    always_comb begin
        actvNext_s = actv_r;
        aoNext_s   = ao_r;
        aoeNext_s  = aoe_r;
        nWeNext_s  = nWe_r;
        nIo2Next_s = nIo2_r;
        doNext_s   = do_r;
        doeNext_s  = doe_r;
        busCycle_s = (stateNext_s == ST_WR) || (stateNext_s == ST_POLL);
        if (cycEnd_s) begin
            doeNext_s = 1'b0;
            if (busCycle_s && nDMA) begin
                actvNext_s = 1'b1;
                aoNext_s   = {IO2_PAGE, 4'h0, (stateNext_s == ST_WR) ? wrReg(idxNext_s) : 4'h0};
                aoeNext_s  = 1'b1;
                nIo2Next_s = 1'b0;
                nWeNext_s  = (stateNext_s != ST_WR);
            end else begin
                actvNext_s = 1'b0;
                aoNext_s   = 16'h0000;
                aoeNext_s  = 1'b0;
                nIo2Next_s = 1'b1;
                nWeNext_s  = 1'b1;
            end
        end else if ((ph_r == 3'd3) && actv_r && (state_r == ST_WR)) begin
            doeNext_s = 1'b1;
            doNext_s  = wrData(idx_r, caddr_r, raddr_r, len_r, xtype_r);
        end else begin
            doeNext_s = doe_r;
        end
    end

    // State, phase and output registers.
    always_ff @(posedge C8M) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            ph_r      <= 3'd0;
            idx_r     <= 4'd0;
            pollCnt_r <= 20'd0;
            pend_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            status_r  <= 8'h00;
            actv_r    <= 1'b0;
            ao_r      <= 16'h0000;
            aoe_r     <= 1'b0;
            nWe_r     <= 1'b1;
            nIo2_r    <= 1'b1;
            do_r      <= 8'h00;
            doe_r     <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            ph_r      <= ph_r + 3'd1;
            idx_r     <= idxNext_s;
            pollCnt_r <= pollNext_s;
            pend_r    <= pendNext_s;
            busy_r    <= busyNext_s;
            done_r    <= doneNext_s;
            err_r     <= errNext_s;
            status_r  <= statusNext_s;
            actv_r    <= actvNext_s;
            ao_r      <= aoNext_s;
            aoe_r     <= aoeNext_s;
            nWe_r     <= nWeNext_s;
            nIo2_r    <= nIo2Next_s;
            do_r      <= doNext_s;
            doe_r     <= doeNext_s;
        end
    end

    // Transfer parameters captured when a request is accepted.
    always_ff @(posedge C8M) begin
        if (RESET) begin
            xtype_r <= 2'b00;
            caddr_r <= 16'h0000;
            raddr_r <= 24'h000000;
            len_r   <= 16'h0000;
        end else if (accept_s) begin
            xtype_r <= XTYPE;
            caddr_r <= CADDR;
            raddr_r <= RADDR;
            len_r   <= LEN;
        end else begin
            xtype_r <= xtype_r;
            caddr_r <= caddr_r;
            raddr_r <= raddr_r;
            len_r   <= len_r;
        end
    end

    assign PHI2   = ph_r[2];
    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign ERR    = err_r;
    assign STATUS = status_r;
    assign A_O    = ao_r;
    assign AOE    = aoe_r;
    assign D_O    = do_r;
    assign DOE    = doe_r;
    assign nWE    = nWe_r;
    assign nIO2   = nIo2_r;

endmodule

// File: tb/tb_reu_host_seq.sv
// Directed bench for reu_host_seq: a main instance for programming/poll/stall
// scenarios and a short-timeout instance for the abort path.
module tb_reu_host_seq;

    logic        c8m = 1'b0;
    logic        reset, start, startT, nDma;
    logic [1:0]  xtype;
    logic [15:0] caddr, len;
    logic [23:0] raddr;
    logic [7:0]  dIn;
    logic [7:0]  dInT = 8'h00;
    logic        nDmaT = 1'b1;

    logic        busy, done, err, phi2, aoe, doe, nWe, nIo2;
    logic [7:0]  status, dOut;
    logic [15:0] aO;
    logic        busyT, doneT, errT, phi2T, aoeT, doeT, nWeT, nIo2T;
    logic [7:0]  statusT, dOutT;
    logic [15:0] aOT;

    int          total = 0;
    int          bad = 0;
    int          clkCnt = 0;
    logic [2:0]  tbPh;

    logic [15:0] cycA;
    logic        cycAoe, cycNio2, cycNwe, cycDoe0, cycDoe5, cycBusy, cycErr;
    logic [7:0]  cycDo, cycStatus;
    int          cycClk, wrStartClk;

    logic [35:0] regOrder = {4'h1, 4'hA, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2};
    logic [71:0] t1Data = {8'h90, 8'h00, 8'h00, 8'h10, 8'h05, 8'h67, 8'h89, 8'h12, 8'h34};
    logic [71:0] t2Data = {8'h93, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'hEF, 8'hC0, 8'h00};
    logic [71:0] t3Data = {8'h91, 8'h00, 8'h06, 8'h07, 8'h03, 8'h04, 8'h05, 8'h01, 8'h02};

    always #5 c8m = ~c8m;

    always @(posedge c8m) begin
        if (reset) tbPh <= 3'd0;
        else       tbPh <= tbPh + 3'd1;
        clkCnt <= clkCnt + 1;
    end

    reu_host_seq u_dut (
        .C8M(c8m), .RESET(reset), .START(start), .XTYPE(xtype), .CADDR(caddr),
        .RADDR(raddr), .LEN(len), .BUSY(busy), .DONE(done), .ERR(err),
        .STATUS(status), .PHI2(phi2), .A_O(aO), .AOE(aoe), .D_I(dIn), .D_O(dOut),
        .DOE(doe), .nWE(nWe), .nIO2(nIo2), .nDMA(nDma)
    );

    reu_host_seq #(.TIMEOUT(20'd16)) u_to (
        .C8M(c8m), .RESET(reset), .START(startT), .XTYPE(xtype), .CADDR(caddr),
        .RADDR(raddr), .LEN(len), .BUSY(busyT), .DONE(doneT), .ERR(errT),
        .STATUS(statusT), .PHI2(phi2T), .A_O(aOT), .AOE(aoeT), .D_I(dInT), .D_O(dOutT),
        .DOE(doeT), .nWE(nWeT), .nIO2(nIo2T), .nDMA(nDmaT)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic toPh(input logic [2:0] p);
        @(negedge c8m);
        while (tbPh != p) @(negedge c8m);
    endtask

    // Capture one bus cycle: control at PH0, write data/enable at PH5.
    task automatic busCycle();
        toPh(3'd0);
        cycA = aO; cycAoe = aoe; cycNio2 = nIo2; cycNwe = nWe; cycDoe0 = doe;
        cycBusy = busy; cycErr = err; cycStatus = status; cycClk = clkCnt;
        while (tbPh != 3'd5) @(negedge c8m);
        cycDoe5 = doe; cycDo = dOut;
    endtask

    task automatic doWrites(input string tag, input logic [71:0] dv, input int n);
        for (int i = 0; i < n; i++) begin
            busCycle();
            if (i == 0) begin
                wrStartClk = cycClk;
                chk({tag, "_clr"}, {cycErr, cycStatus}, 9'h000);
            end
            chk($sformatf("%s_w%0d_addr", tag, i), cycA, {8'hDF, 4'h0, regOrder[4*i +: 4]});
            chk($sformatf("%s_w%0d_ctl", tag, i),
                {cycAoe, cycNio2, cycNwe, cycDoe0, cycDoe5, cycBusy}, 6'b100011);
            chk($sformatf("%s_w%0d_data", tag, i), cycDo, dv[8*i +: 8]);
        end
    endtask

    int   k;
    logic seen;
    logic anyAct;

    initial begin
        reset = 1'b1; start = 1'b0; startT = 1'b0; nDma = 1'b1; dIn = 8'h00;
        xtype = 2'b00; caddr = 16'h0000; raddr = 24'h000000; len = 16'h0000;
        repeat (3) @(posedge c8m);
        @(negedge c8m);
        chk("rst_out", {phi2, aO, aoe, dOut, doe, nWe, nIo2, busy, done, err, status},
            {1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        chk("rst_to", {busyT, aoeT, nIo2T, doneT, errT, statusT, phi2T, aOT, dOutT, doeT, nWeT},
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1});
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge c8m);
            chk("idle", {phi2, nIo2, aoe, busy}, {tbPh[2], 1'b1, 1'b0, 1'b0});
        end

        // Copy C64->REU, START mid-revolution is held until PH=7
        xtype = 2'b00; caddr = 16'h1234; raddr = 24'h056789; len = 16'h0010;
        toPh(3'd2); start = 1'b1;
        @(negedge c8m); start = 1'b0;
        toPh(3'd6);
        chk("t1_pending", {busy, aoe}, 2'b00);
        doWrites("t1", t1Data, 9);
        busCycle();
        chk("t1_rd_addr", cycA, 16'hDF00);
        chk("t1_rd_ctl", {cycAoe, cycNio2, cycNwe, cycDoe0, cycDoe5}, 5'b10100);
        chk("t1_rd_lat", 64'(cycClk - wrStartClk), 64'd72);
        nDma = 1'b0;
        for (int i = 0; i < 32; i++) begin
            busCycle();
            chk("t1_stall", {cycAoe, cycNio2, cycNwe, cycDoe0, cycDoe5, cycBusy, done}, 7'b0110010);
        end
        nDma = 1'b1; dIn = 8'h40;
        busCycle();
        chk("t1_rd2", {cycA, cycAoe, cycNio2}, {16'hDF00, 1'b1, 1'b0});
        toPh(3'd7);
        chk("t1_pre_done", {done, busy}, 2'b01);
        @(negedge c8m);
        chk("t1_done", {done, busy, err, aoe, status}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h40});
        @(negedge c8m);
        chk("t1_pulse", done, 1'b0);
        dIn = 8'h00;

        // Verify with mismatch flag; LEN=0 passes through unchanged
        xtype = 2'b11; caddr = 16'hC000; raddr = 24'hABCDEF; len = 16'h0000;
        toPh(3'd7); start = 1'b1;
        @(posedge c8m); #1 start = 1'b0;
        doWrites("t2", t2Data, 9);
        dIn = 8'h60;
        busCycle();
        toPh(3'd7);
        @(negedge c8m);
        chk("t2_done", {done, busy, err, status}, {1'b1, 1'b0, 1'b1, 8'h60});
        dIn = 8'h00;
        repeat (20) @(negedge c8m);
        chk("t2_hold", {err, status, busy, done}, {1'b1, 8'h60, 1'b0, 1'b0});

        // Reset during the fifth write, then a clean restart
        xtype = 2'b01; caddr = 16'h0102; raddr = 24'h030405; len = 16'h0607;
        toPh(3'd7); start = 1'b1;
        @(posedge c8m); #1 start = 1'b0;
        doWrites("t3a", t3Data, 4);
        busCycle();
        chk("t3_w5", {cycA, cycDoe5}, {16'hDF06, 1'b1});
        reset = 1'b1;
        @(negedge c8m);
        chk("t3_rst", {nIo2, aoe, busy, done, doe, nWe, err, status, aO},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000});
        reset = 1'b0;
        anyAct = 1'b0;
        repeat (16) begin
            @(negedge c8m);
            anyAct = anyAct | done | busy | aoe;
        end
        chk("t3_quiet", anyAct, 1'b0);
        toPh(3'd7); start = 1'b1;
        @(posedge c8m); #1 start = 1'b0;
        doWrites("t3b", t3Data, 9);
        dIn = 8'h40;
        busCycle();
        toPh(3'd7);
        @(negedge c8m);
        chk("t3_done", {done, err, status}, {1'b1, 1'b0, 8'h40});
        dIn = 8'h00;

        // Timeout instance: status never completes, second START while busy
        toPh(3'd7); startT = 1'b1;
        @(posedge c8m); #1 startT = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 400) begin
            @(negedge c8m);
            if (doneT === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (k == 103) chk("to_busy", busyT, 1'b1);
                startT = (k == 103);
                k++;
            end
        end
        startT = 1'b0;
        chk("to_seen", seen, 1'b1);
        chk("to_lat", 64'(k), 64'd200);
        chk("to_res", {errT, statusT, busyT}, {1'b1, 8'h00, 1'b0});
        anyAct = 1'b0;
        repeat (40) begin
            @(negedge c8m);
            anyAct = anyAct | busyT | aoeT | doneT;
        end
        chk("to_ignored", anyAct, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
